// File: rtl/dec_pkg.sv
// Shared types for the ECC decoder output path: error codes and the buffered word format.
package dec_pkg;

  localparam int DEC_MAX_INFO_W = 26;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_RSVD   = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [DEC_MAX_INFO_W-1:0] data;
    err_code_e                 errors;
  } dec_word_t;

  // The reserved code is counted as uncorrectable, so bit 1 alone decides it.
  function automatic logic is_uncorrectable(input err_code_e e);
    return e[1];
  endfunction

endpackage

// File: rtl/dec_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module dec_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dec_out_buffer.sv
// Show-ahead FIFO behind the ECC decoder with drop/error statistics and a sticky
// uncorrectable-error interrupt. Handshake: a word moves when valid and ready are both high.
module dec_out_buffer
  import dec_pkg::*;
#(
  parameter int MAX_INFO_WIDTH = DEC_MAX_INFO_W,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [MAX_INFO_WIDTH-1:0] in_data,
  input  logic [1:0]                in_errors,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [MAX_INFO_WIDTH-1:0] out_data,
  output logic [1:0]                out_errors,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_WIDTH-1:0]      corrected_cnt,
  output logic [CNT_WIDTH-1:0]      uncorr_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt,
  input  logic                      clr_cnt,
  output logic                      err_irq,
  input  logic                      irq_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  dec_word_t        mem_q [DEPTH];
  dec_word_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             err_irq_q, err_irq_d;

  logic      push, pop, drop;
  dec_word_t in_word;
  err_code_e in_code;

  // Readiness comes from the registered level only, so a pop cannot open a slot for the same cycle.
  assign in_ready  = (level_q < LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;

  assign in_code        = err_code_e'(in_errors);
  assign in_word.data   = in_data;
  assign in_word.errors = in_code;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    err_irq_d = err_irq_q;
    if (irq_clr) err_irq_d = 1'b0;
    if (push && is_uncorrectable(in_code)) err_irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_irq_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_irq_q <= err_irq_d;
    end
  end

  assign out_data   = mem_q[rd_ptr_q].data;
  assign out_errors = mem_q[rd_ptr_q].errors;
  assign level      = level_q;
  assign err_irq    = err_irq_q;

  dec_sat_counter #(.WIDTH(CNT_WIDTH)) u_corrected_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push && (in_code == ERR_SINGLE)),
    .clr (clr_cnt),
    .cnt (corrected_cnt)
  );

  dec_sat_counter #(.WIDTH(CNT_WIDTH)) u_uncorr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push && is_uncorrectable(in_code)),
    .clr (clr_cnt),
    .cnt (uncorr_cnt)
  );

  dec_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .clr (clr_cnt),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_dec_out_buffer.sv
// Directed bench for dec_out_buffer: a vector table for the main paths plus
// hand-written sequences for saturation, pointer wrap and asynchronous reset.
module tb_dec_out_buffer;

  localparam int W     = 26;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_errors = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_errors;
  logic          out_ready = 1'b0;
  logic [2:0]    level;
  logic [CW-1:0] corrected_cnt, uncorr_cnt, drop_cnt;
  logic          clr_cnt = 1'b0;
  logic          err_irq;
  logic          irq_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  dec_out_buffer #(.MAX_INFO_WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_errors     (in_errors),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_errors    (out_errors),
    .out_ready     (out_ready),
    .level         (level),
    .corrected_cnt (corrected_cnt),
    .uncorr_cnt    (uncorr_cnt),
    .drop_cnt      (drop_cnt),
    .clr_cnt       (clr_cnt),
    .err_irq       (err_irq),
    .irq_clr       (irq_clr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [W-1:0]  d;
    logic [1:0]    e;
    logic          ordy;
    logic          iclr;
    logic          cclr;
    logic          ev;
    logic [W-1:0]  ed;
    logic [1:0]    ee;
    logic [2:0]    el;
    logic [CW-1:0] ec;
    logic [CW-1:0] eu;
    logic [CW-1:0] edr;
    logic          eirq;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic iv, input int d, input int e, input logic ordy,
                              input logic iclr, input logic cclr, input logic ev, input int ed,
                              input int ee, input int el, input int ec, input int eu,
                              input int edr, input logic eirq);
    vec_t v;
    v.iv = iv; v.d = W'(d); v.e = 2'(e); v.ordy = ordy; v.iclr = iclr; v.cclr = cclr;
    v.ev = ev; v.ed = W'(ed); v.ee = 2'(ee); v.el = 3'(el);
    v.ec = CW'(ec); v.eu = CW'(eu); v.edr = CW'(edr); v.eirq = eirq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic [1:0] e,
                       input logic ordy, input logic iclr, input logic cclr);
    @(negedge clk);
    in_valid = iv; in_data = d; in_errors = e;
    out_ready = ordy; irq_clr = iclr; clr_cnt = cclr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rows: stimulus, then expected state after the edge. Data is only checked when valid.
    tbl[0]  = mk(1, 'h3A5, 0, 1, 0, 0,  1, 'h3A5, 0, 1,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0,     0, 1, 0, 0,  0, 0,     0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(1, 'h11,  0, 0, 0, 0,  1, 'h11,  0, 1,  0, 0, 0, 0);
    tbl[3]  = mk(1, 'h12,  0, 0, 0, 0,  1, 'h11,  0, 2,  0, 0, 0, 0);
    tbl[4]  = mk(1, 'h13,  0, 0, 0, 0,  1, 'h11,  0, 3,  0, 0, 0, 0);
    tbl[5]  = mk(1, 'h14,  0, 0, 0, 0,  1, 'h11,  0, 4,  0, 0, 0, 0);
    tbl[6]  = mk(1, 'h15,  0, 0, 0, 0,  1, 'h11,  0, 4,  0, 0, 1, 0);
    tbl[7]  = mk(1, 'h16,  0, 1, 0, 0,  1, 'h12,  0, 3,  0, 0, 2, 0);
    tbl[8]  = mk(0, 0,     0, 1, 0, 0,  1, 'h13,  0, 2,  0, 0, 2, 0);
    tbl[9]  = mk(0, 0,     0, 1, 0, 0,  1, 'h14,  0, 1,  0, 0, 2, 0);
    tbl[10] = mk(0, 0,     0, 1, 0, 0,  0, 0,     0, 0,  0, 0, 2, 0);
    tbl[11] = mk(1, 'h21,  1, 1, 0, 0,  1, 'h21,  1, 1,  1, 0, 2, 0);
    tbl[12] = mk(1, 'h22,  2, 1, 0, 0,  1, 'h22,  2, 1,  1, 1, 2, 1);
    tbl[13] = mk(1, 'h23,  3, 1, 0, 0,  1, 'h23,  3, 1,  1, 2, 2, 1);
    tbl[14] = mk(1, 'h24,  0, 1, 0, 0,  1, 'h24,  0, 1,  1, 2, 2, 1);
    tbl[15] = mk(0, 0,     0, 1, 1, 0,  0, 0,     0, 0,  1, 2, 2, 0);
    tbl[16] = mk(1, 'h25,  2, 1, 0, 0,  1, 'h25,  2, 1,  1, 3, 2, 1);
    tbl[17] = mk(1, 'h26,  2, 1, 1, 0,  1, 'h26,  2, 1,  1, 4, 2, 1);
    tbl[18] = mk(0, 0,     0, 1, 1, 0,  0, 0,     0, 0,  1, 4, 2, 0);
    tbl[19] = mk(0, 0,     0, 0, 0, 1,  0, 0,     0, 0,  0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_level",     32'(level),     32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_err",   32'(out_errors), 32'd0);
    check("rst_cnts",      32'({corrected_cnt, uncorr_cnt, drop_cnt}), 32'd0);
    check("rst_irq",       32'(err_irq),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].e, tbl[i].ordy, tbl[i].iclr, tbl[i].cclr);
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].ed));
        check($sformatf("v%0d_out_err", i),  32'(out_errors), 32'(tbl[i].ee));
      end
      check($sformatf("v%0d_level", i),    32'(level), 32'(tbl[i].el));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].el < 3'(DEPTH)));
      check($sformatf("v%0d_corr", i),     32'(corrected_cnt), 32'(tbl[i].ec));
      check($sformatf("v%0d_uncorr", i),   32'(uncorr_cnt), 32'(tbl[i].eu));
      check($sformatf("v%0d_drop", i),     32'(drop_cnt), 32'(tbl[i].edr));
      check($sformatf("v%0d_irq", i),      32'(err_irq), 32'(tbl[i].eirq));
    end

    // Saturation: 20 corrected words into a 4-bit counter hold at 0xF
    for (int i = 0; i < 20; i++) drive(1'b1, W'(32'h40 + i), 2'd1, 1'b1, 1'b0, 1'b0);
    check("sat_corr",   32'(corrected_cnt), 32'hF);
    check("sat_uncorr", 32'(uncorr_cnt), 32'd0);
    check("sat_level",  32'(level), 32'd1);
    check("sat_head",   32'(out_data), 32'h53);
    drive(1'b1, W'(32'h60), 2'd1, 1'b1, 1'b0, 1'b1);
    check("clr_wins_corr", 32'(corrected_cnt), 32'd0);
    check("clr_push_head", 32'(out_data), 32'h60);
    drive(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("sat_drained", 32'(level), 32'd0);

    // Steady push+pop at level 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, W'(32'h100 + i), 2'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(W'(32'h100 + i));
    end
    check("wrap_fill_level", 32'(level), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(32'h102 + i), 2'd0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(W'(32'h102 + i));
      void'(exp_q.pop_front());
      check($sformatf("wrap%0d_level", i), 32'(level), 32'd2);
      check($sformatf("wrap%0d_head", i),  32'(out_data), 32'(exp_q[0]));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      if (exp_q.size() > 0) check("wrap_drain_head", 32'(out_data), 32'(exp_q[0]));
    end
    check("wrap_drained", 32'(level), 32'd0);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) drive(1'b1, W'(32'h200 + i), 2'd2, 1'b0, 1'b0, 1'b0);
    check("pre_rst_level",  32'(level), 32'd3);
    check("pre_rst_irq",    32'(err_irq), 32'd1);
    check("pre_rst_uncorr", 32'(uncorr_cnt), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_level",     32'(level), 32'd0);
    check("arst_in_ready",  32'(in_ready), 32'd1);
    check("arst_cnts",      32'({corrected_cnt, uncorr_cnt, drop_cnt}), 32'd0);
    check("arst_irq",       32'(err_irq), 32'd0);
    check("arst_out_data",  32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, W'(32'h3C), 2'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data",  32'(out_data), 32'h3C);
    check("post_rst_level", 32'(level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_out_buffer.md
# dec_out_buffer

Output stage directly downstream of the ECC decoder. Accepts one decoded word per cycle (info bits plus 2-bit error count), buffers it in a small show-ahead FIFO, and presents it to the consumer over a valid/ready handshake. Keeps saturating statistics of corrected, uncorrectable and dropped words, and raises a sticky interrupt on uncorrectable errors. The decoder has no backpressure, so words arriving while the FIFO is full are dropped and counted.

## Interface
- MAX_INFO_WIDTH, 26, width of decoded info word, zero-padded by decoder for smaller modes
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoder word present this cycle
- in_data  in  MAX_INFO_WIDTH  decoded info word
- in_errors  in  2  decoder num_of_errors: 0 none, 1 corrected, 2 uncorrectable, 3 reserved
- in_ready  out  1  FIFO not full; advisory only, decoder does not stall
- out_valid  out  1  head entry valid
- out_data  out  MAX_INFO_WIDTH  head entry data
- out_errors  out  2  head entry error code
- out_ready  in  1  consumer accepts head entry
- level  out  $clog2(DEPTH)+1  current occupancy
- corrected_cnt  out  CNT_WIDTH  accepted words with in_errors==1
- uncorr_cnt  out  CNT_WIDTH  accepted words with in_errors≥2
- drop_cnt  out  CNT_WIDTH  words lost to full FIFO
- clr_cnt  in  1  synchronous clear of all three counters
- err_irq  out  1  sticky: an uncorrectable word was accepted
- irq_clr  in  1  synchronous clear of err_irq

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level < DEPTH); no write-through when full, even if popping the same cycle.
- in_valid & !in_ready: word discarded, drop_cnt +1, FIFO unchanged.
- Push and pop in the same cycle (not full, not empty): level unchanged, both take effect.
- Code 3 is treated as uncorrectable for counting and IRQ; stored unchanged in FIFO.
- Counters increment only on push (drop_cnt on drop); saturate at all-ones, never wrap.
- clr_cnt wins over a same-cycle increment: all counters become 0.
- err_irq set on push with in_errors≥2; irq_clr clears; set wins over clear in the same cycle.
- Read/write pointers are log2(DEPTH) bits, wrap naturally; level tracks full/empty.
- out_data/out_errors hold the head entry while out_valid; don't-care (stable last value) when empty.

## Timing
- Reset (rst low, async): level=0, pointers 0, out_valid=0, in_ready=1, all counters 0, err_irq=0, out_data/out_errors=0.
- Reset mid-operation discards all FIFO contents immediately; first push after release accepted on the first rising edge with rst high.
- Push at edge N: out_valid=1 after edge N (1-cycle latency into an empty FIFO).
- Pop at edge N: next entry (if any) on out_data after edge N; out_valid drops after edge N if it was the last.
- Counter and err_irq updates visible the cycle after the triggering edge.
- All outputs registered or derived from registered level only; no combinational in→out path.

## Structure
- Shared package dec_pkg: err_code_e enum (ERR_NONE=0, ERR_SINGLE=1, ERR_DOUBLE=2, ERR_RSVD=3); dec_word_t struct {data, errors} used as the FIFO entry type.
- Sub-module dec_sat_counter (params WIDTH; inputs inc, clr; output cnt), instantiated three times.
- FIFO storage as a flat register array of dec_word_t; no memory macro.

## Test plan
- Reset then push 0x3A5 err 0, out_ready=1 → out_valid 1 cycle later with 0x3A5/0; level returns to 0; all counters 0.
- out_ready=0, push 6 words with DEPTH=4 → in_ready low after 4th, level=4, drop_cnt=2; pop all returns words 1–4 in order.
- Push err codes 1,2,3,0 → corrected_cnt=1, uncorr_cnt=2, err_irq=1; irq_clr and a code-2 push same cycle → err_irq stays 1.
- Force corrected_cnt to 0xFFFF via CNT_WIDTH=4 build and 20 code-1 pushes → holds 0xF; clr_cnt with push → 0.
- Continuous push+pop with level=2 for 10 cycles → level stays 2, data in order, pointer wrap verified.
- Assert rst low with level=3 mid-stream → out_valid, level, counters, err_irq 0 asynchronously before next edge.
